spram2flash: RTL
================

// Module: spram2flash
// PURPOSE
//  Saves a SPRAM region back to SPI flash (save-RAM write-back); inverse of the flash->SPRAM boot loader.
//  Per 4 KiB sector: WREN, sector erase, WIP poll; then per chunk: WREN, page program, WIP poll.
//  Drives the shared SPI user interface. Top muxes SPI between loader and this block (loader owns it until load_done).
// PARAMETERS
//  SAVE_OFFSET  24'h0F0000  flash byte address of save area; 4 KiB aligned
//  SAVE_SIZE    24'h008000  bytes to save; nonzero multiple of 4096
//  SRAM_BASE    17'h18000   SPRAM byte address of save area; addr wraps mod 2^17
//  PROG_BYTES   128         bytes per page-program; power of 2, 1..128 (4+PROG_BYTES <= 255)
// PORTS
//  clk           in   1   clock
//  reset_n       in   1   synchronous, active-low reset
//  start         in   1   request save; sampled only in S_IDLE
//  busy          out  1   high from accepted start until done pulse (inclusive)
//  done          out  1   one-cycle pulse when last program's WIP poll reads 0
//  spram_addr    out  17  SPRAM byte read address
//  spram_re      out  1   read strobe; spram_rd valid exactly 1 cycle later
//  spram_rd      in   8   SPRAM read data
//  spi_enable    out  1   one-cycle pulse starts a transaction
//  spi_idle      in   1   master idle; rising edge = transaction complete
//  spi_tx_len    out  8   bytes to send
//  spi_tx_fetch  in   1   pulse: master consumed spi_tx_data
//  spi_tx_data   out  8   current tx byte
//  spi_rx_len    out  24  bytes to receive after tx
//  spi_rx_store  in   1   pulse: spi_rx_data valid
//  spi_rx_data   in   8   received byte
// BEHAVIOUR
//  Reset: state S_IDLE; busy, done, spi_enable, spram_re = 0; spi_tx_len=1, spi_rx_len=0, spi_tx_data=0, spram_addr=SRAM_BASE.
//  Reset mid-operation: abort immediately to S_IDLE, no further spi_enable; flash contents undefined (accepted).
//  SPI rules: spi_tx_len, spi_rx_len, first tx byte registered and stable from spi_enable cycle until spi_idle rise.
//   Byte i+1 presented on spi_tx_data within 2 cycles of fetch of byte i; master guarantees >= 8 clk between fetches.
//   Completion = spi_idle & ~spi_idle_q (registered edge detect); spi_enable never issued while spi_idle low.
//  States / transitions (each command state pulses spi_enable on entry):
//   S_IDLE   : start -> S_WREN, sec_off=0, chunk_off=0, phase=ERASE, busy=1. start while busy ignored.
//   S_WREN   : tx {06}, len 1/0; done -> phase==ERASE ? S_ERASE : S_PROG.
//   S_ERASE  : tx {20, A[23:16], A[15:8], A[7:0]}, A=SAVE_OFFSET+sec_off; done -> S_POLL.
//   S_POLL   : tx {05}, rx_len 1; status latched on spi_rx_store; done -> WIP(bit0)=1 ? S_POLL (reissue) : S_NEXT.
//   S_PROG   : tx {02, A2,A1,A0, D[0..PROG_BYTES-1]}, A=SAVE_OFFSET+sec_off+chunk_off, tx_len=4+PROG_BYTES;
//              D[k] = SPRAM[SRAM_BASE+sec_off+chunk_off+k]; done -> S_POLL.
//   S_NEXT   : phase ERASE -> phase=PROG, chunk_off=0 -> S_WREN.
//              phase PROG: chunk_off+=PROG_BYTES; if chunk_off wraps to 4096: sec_off+=4096, chunk_off=0;
//              if sec_off==SAVE_SIZE -> S_DONE else phase=ERASE -> S_WREN. Otherwise -> S_WREN.
//   S_DONE   : done=1 one cycle, busy=0 next cycle -> S_IDLE.
//  Data fetch: on fetch of header byte 3 and each data byte except the last, spram_re pulses with next addr;
//   spram_rd registered into spi_tx_data the cycle after. spram_re never asserted outside S_PROG.
//  Widths: flash addr 24-bit add, no wrap check (parameter legality is caller's job); SPRAM addr 17-bit wrap.
//  Extra spi_tx_fetch beyond tx_len or spi_rx_store outside S_POLL: ignored, no state change.
// STRUCTURE
//  Package flash_cmd_pkg: opcodes CMD_WREN=06, CMD_SE=20, CMD_PP=02, CMD_RDSR=05, CMD_RSTEN=66, CMD_RST=99,
//   SECTOR_BYTES=4096, state enum s_s2f; loader to import same opcodes.
//  One sub-module: spram2flash_txsrc — header/SPRAM byte mux, tx index counter, prefetch pipeline.
// TESTING (bench: behavioural SPI flash model with configurable WIP busy count, SPRAM model 1-cycle read)
//  1 SAVE_SIZE=4096, PROG_BYTES=128, WIP busy 0 polls -> 06,20 0F0000, 05, then 32x(06,02 addr,128 B,05); flash==SPRAM; one done.
//  2 WIP busy 3 polls after erase -> exactly 4 RDSR after erase before first WREN; no spram_re during polls.
//  3 SAVE_SIZE=8192 -> second erase at 0F1000 only after 32nd program of sector 0 completes; data at 0F1000 = SPRAM[19000].
//  4 SRAM_BASE=17'h1FF80, PROG_BYTES=128, 2 chunks -> second chunk reads SPRAM 00000..0007F (wrap).
//  5 start pulsed while busy, and held high in S_DONE cycle -> ignored / no restart until S_IDLE samples it.
//  6 reset_n low mid S_PROG (byte 50) -> next cycle S_IDLE, spi_enable/busy/spram_re 0; fresh start completes correctly.

Source files
------------

// File: rtl/flash_cmd_pkg.sv
// SPI NOR flash opcodes and the save-back FSM state type, shared with the
// flash->SPRAM boot loader so both agree on the command set.
package flash_cmd_pkg;

  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_SE    = 8'h20;
  localparam logic [7:0] CMD_PP    = 8'h02;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_RSTEN = 8'h66;
  localparam logic [7:0] CMD_RST   = 8'h99;

  localparam int SECTOR_BYTES = 4096;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WREN  = 3'd1,
    S_ERASE = 3'd2,
    S_POLL  = 3'd3,
    S_PROG  = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } s_s2f;

endpackage

// File: rtl/spram2flash_txsrc.sv
// Transmit byte source: opcode/address header, then SPRAM data prefetched one
// byte ahead so each byte is on spi_tx_data two cycles after the previous fetch.
module spram2flash_txsrc #(
  parameter logic [16:0] SRAM_BASE = 17'h18000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [7:0]  opcode,
  input  logic [23:0] flash_addr,
  input  logic [16:0] spram_start,
  input  logic [7:0]  tx_len,
  input  logic        with_data,
  input  logic        active,
  input  logic        spi_tx_fetch,
  output logic [7:0]  spi_tx_data,
  output logic [16:0] spram_addr,
  output logic        spram_re,
  input  logic [7:0]  spram_rd
);

  logic [23:0] hdr_q;
  logic [7:0]  cnt;
  logic        data_q;
  logic        rd_pend;
  logic        fetch_ok;
  logic [7:0]  hdr_byte;

  // cnt is the index of the byte being consumed; fetches past tx_len are ignored.
  assign fetch_ok = active & spi_tx_fetch & (cnt < tx_len);
  assign spram_re = fetch_ok & data_q & (cnt >= 8'd3) & (cnt < tx_len - 8'd1);

  always_comb begin
    hdr_byte = hdr_q[7:0];
    case (cnt)
      8'd0:    hdr_byte = hdr_q[23:16];
      8'd1:    hdr_byte = hdr_q[15:8];
      default: hdr_byte = hdr_q[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      spi_tx_data <= 8'h00;
      spram_addr  <= SRAM_BASE;
      hdr_q       <= 24'h0;
      cnt         <= 8'd0;
      data_q      <= 1'b0;
      rd_pend     <= 1'b0;
    end else begin
      rd_pend <= spram_re;
      if (load) begin
        spi_tx_data <= opcode;
        hdr_q       <= flash_addr;
        data_q      <= with_data;
        cnt         <= 8'd0;
        spram_addr  <= spram_start;
      end else begin
        if (fetch_ok) begin
          cnt <= cnt + 8'd1;
          if (cnt < 8'd3 && (cnt + 8'd1) < tx_len) spi_tx_data <= hdr_byte;
        end
        if (spram_re) spram_addr <= spram_addr + 17'd1;
        if (rd_pend)  spi_tx_data <= spram_rd;
      end
    end
  end

endmodule

// File: rtl/spram2flash.sv
// Writes a SPRAM region back to SPI flash: per sector WREN/erase/poll, then per
// chunk WREN/page-program/poll, driving the shared SPI user interface.
module spram2flash
  import flash_cmd_pkg::*;
#(
  parameter logic [23:0] SAVE_OFFSET = 24'h0F0000,
  parameter logic [23:0] SAVE_SIZE   = 24'h008000,
  parameter logic [16:0] SRAM_BASE   = 17'h18000,
  parameter int          PROG_BYTES  = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [16:0] spram_addr,
  output logic        spram_re,
  input  logic [7:0]  spram_rd,
  output logic        spi_enable,
  input  logic        spi_idle,
  output logic [7:0]  spi_tx_len,
  input  logic        spi_tx_fetch,
  output logic [7:0]  spi_tx_data,
  output logic [23:0] spi_rx_len,
  input  logic        spi_rx_store,
  input  logic [7:0]  spi_rx_data,
  output logic [2:0]  dbg_state
);

  localparam logic [7:0] PP_LEN = 8'(4 + PROG_BYTES);

  s_s2f        state, state_d;
  logic        launched, spi_idle_q, wip_q;
  logic        phase_prog, phase_d;
  logic [23:0] sec_off, sec_d;
  logic [11:0] chunk_off, chunk_d;
  logic [12:0] chunk_sum;
  logic        cmd_state, launch, xfer_done;
  logic [7:0]  cmd_op, cmd_len;
  logic [23:0] cmd_rx;
  logic [23:0] flash_addr;
  logic [16:0] spram_start;
  logic        unused_rx;

  // Handshake: spi_enable is a one-cycle pulse issued only while spi_idle is
  // high; lengths and the first tx byte are registered with it and held until
  // the transaction completes, signalled by the rising edge of spi_idle.
  assign cmd_state = (state == S_WREN) || (state == S_ERASE) ||
                     (state == S_POLL) || (state == S_PROG);
  assign launch    = cmd_state & ~launched & spi_idle;
  assign xfer_done = launched & spi_idle & ~spi_idle_q;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;
  assign unused_rx = ^spi_rx_data[7:1];

  assign chunk_sum   = {1'b0, chunk_off} + 13'(PROG_BYTES);
  assign flash_addr  = SAVE_OFFSET + sec_off + {12'd0, chunk_off};
  assign spram_start = SRAM_BASE + sec_off[16:0] + {5'd0, chunk_off};

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    sec_d   = sec_off;
    chunk_d = chunk_off;
    phase_d = phase_prog;
    cmd_op  = CMD_WREN;
    cmd_len = 8'd1;
    cmd_rx  = 24'd0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_WREN;
          sec_d   = 24'd0;
          chunk_d = 12'd0;
          phase_d = 1'b0;
        end
      end
      S_WREN: begin
        if (xfer_done) state_d = phase_prog ? S_PROG : S_ERASE;
      end
      S_ERASE: begin
        cmd_op  = CMD_SE;
        cmd_len = 8'd4;
        if (xfer_done) state_d = S_POLL;
      end
      S_POLL: begin
        cmd_op = CMD_RDSR;
        cmd_rx = 24'd1;
        if (xfer_done) state_d = wip_q ? S_POLL : S_NEXT;
      end
      S_PROG: begin
        cmd_op  = CMD_PP;
        cmd_len = PP_LEN;
        if (xfer_done) state_d = S_POLL;
      end
      S_NEXT: begin
        if (!phase_prog) begin
          phase_d = 1'b1;
          chunk_d = 12'd0;
          state_d = S_WREN;
        end else if (chunk_sum[12]) begin
          chunk_d = 12'd0;
          sec_d   = sec_off + 24'(SECTOR_BYTES);
          if (sec_d == SAVE_SIZE) begin
            state_d = S_DONE;
          end else begin
            phase_d = 1'b0;
            state_d = S_WREN;
          end
        end else begin
          chunk_d = chunk_sum[11:0];
          state_d = S_WREN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      spi_enable <= 1'b0;
      spi_tx_len <= 8'd1;
      spi_rx_len <= 24'd0;
      launched   <= 1'b0;
      spi_idle_q <= 1'b1;
      wip_q      <= 1'b0;
      sec_off    <= 24'd0;
      chunk_off  <= 12'd0;
      phase_prog <= 1'b0;
    end else begin
      spi_idle_q <= spi_idle;
      spi_enable <= launch;
      launched   <= launch | (launched & ~xfer_done);
      if (launch) begin
        spi_tx_len <= cmd_len;
        spi_rx_len <= cmd_rx;
      end
      if (state == S_POLL && launched && spi_rx_store) wip_q <= spi_rx_data[0];
      sec_off    <= sec_d;
      chunk_off  <= chunk_d;
      phase_prog <= phase_d;
    end
  end

  spram2flash_txsrc #(
    .SRAM_BASE(SRAM_BASE)
  ) u_txsrc (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (launch),
    .opcode      (cmd_op),
    .flash_addr  (flash_addr),
    .spram_start (spram_start),
    .tx_len      (spi_tx_len),
    .with_data   (state == S_PROG),
    .active      (launched),
    .spi_tx_fetch(spi_tx_fetch),
    .spi_tx_data (spi_tx_data),
    .spram_addr  (spram_addr),
    .spram_re    (spram_re),
    .spram_rd    (spram_rd)
  );

endmodule
